screen_entry_fetcher: RTL and testbench
=======================================

# screen_entry_fetcher

Fetches one scanline's run of background screen-map entries from VRAM and delivers them, in order, to the BG tile pipeline. Supports text mode (16-bit entries, 2 KB screen-block quadrant layout) and rotation/scaling mode (8-bit entries, linear map, optional wrap). It sits between the BG control registers and the tile/character fetch stage. It issues VRAM reads over a req/ack port and buffers the results in a small FIFO with ready/valid output.

## Interface
- N_TILES, 31: entries fetched per line. Range 1–128.
- FIFO_DEPTH, 4: output FIFO entries. Power of two, ≥2.
- ADDR_W, 16: VRAM byte-address width.
- BASE_W, 5: screen base block width. Unit is 2 KB.
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a line. Ignored unless idle.
- x0  in  10  first pixel x, scroll already applied.
- y  in  10  line y, scroll already applied.
- hmax, vmax  in  10  map width/height in pixels minus 1. Each is 2^k−1 with k = 7..10.
- rotate  in  1  0 = text mode, 1 = rotation mode.
- wrap  in  1  rotation-mode wraparound enable. Text mode always wraps.
- screen_base  in  BASE_W  map base, in 2 KB units.
- busy  out  1  high from the cycle after start acceptance until the final entry is popped.
- mem_req  out  1  VRAM read request.
- mem_addr  out  ADDR_W  byte address of the request. Held stable while mem_req is high.
- mem_ack  in  1  request completes this cycle; mem_rdata is valid.
- mem_rdata  in  16  halfword at mem_addr with bit 0 cleared.
- entry_valid  out  1  FIFO head valid.
- entry_data  out  16  screen entry.
- entry_transparent  out  1  rotation-mode out-of-map tile; entry_data = 0.
- entry_last  out  1  head is entry N_TILES−1.
- entry_ready  in  1  consumer pop.

## Operation
- All inputs are sampled on the start cycle. They are held internally for the whole line.
- FSM states:
  - IDLE: when start = 1, capture inputs, set i = 0, go to FETCH.
  - FETCH: issue entry i. Once i = N_TILES−1 has been pushed, go to DRAIN.
  - DRAIN: when the FIFO is empty after the last pop, go to IDLE.
- Column and row for entry i:
  - tx = x0[9:3] + i, 8-bit unsigned.
  - c = tx & hmax[9:3].
  - r = y[9:3] & vmax[9:3].
- Text-mode address: screen_base·2048 + blk·2048 + r[4:0]·64 + c[4:0]·2.
  - blk = {r[5], c[5]} when hmax = 511.
  - blk = {0, r[5]} otherwise.
  - entry_data = mem_rdata.
- Rotation-mode address: screen_base·2048 + r·((hmax+1)/8) + c.
  - entry_data = {8'h00, byte}.
  - byte = mem_rdata[15:8] if mem_addr[0] = 1, else mem_rdata[7:0].
- Rotation overflow: with wrap = 0, an entry overflows if tx·8 > hmax or y > vmax.
  - No VRAM request is issued for an overflowed entry.
  - The entry is pushed with transparent = 1 and data = 0, consuming one FETCH cycle.
- Address arithmetic is truncated to ADDR_W bits.
- FIFO push on mem_ack, or on an overflow push. FIFO pop on entry_valid & entry_ready.
- entry_last travels with the entry through the FIFO.

## Timing
- Reset values: state IDLE, FIFO empty, i = 0. busy, mem_req, entry_valid, entry_transparent and entry_last are 0. mem_addr and entry_data are 0.
- mem_req is registered. It rises the cycle after FETCH entry or after the previous ack, provided the registered FIFO count < FIFO_DEPTH.
  - A pop in the same cycle does not unblock a full FIFO until the next cycle.
- Throughput: one entry per 2 cycles with a zero-wait ack. Any number of wait cycles is tolerated, with mem_req and mem_addr held.
- Data path: ack in cycle t → entry_valid by cycle t+1. With an empty FIFO, the FIFO head is visible the cycle after the push.
- Back-pressure: at most FIFO_DEPTH entries are outstanding. The FIFO never overflows and mem_req never drops before ack.
- start while busy is ignored, including in DRAIN. A new start is accepted in the first IDLE cycle.
- Reset mid-line: the next cycle is IDLE, the FIFO is flushed and mem_req = 0. A pending ack is discarded.
- tx overflow past 255 wraps modulo 256 before masking.

## Test plan
- Text, base=2, hmax=vmax=255, x0=0, y=8, N_TILES=4, zero-wait ack → mem_addr 0x1040, 0x1042, 0x1044, 0x1046, in order; entry_last on the 4th entry; busy falls after the last pop.
- Text 512×512, base=0, x0=248, y=0, N_TILES=2 → 0x003E then 0x0800 (quadrant 1); with y=256 → 0x1000 + 0x3E, then 0x1800.
- Rotation 128×128, base=0, y=16, x0=120, N_TILES=2, wrap=0 → request to 0x002F with entry = mem_rdata[15:8]; second entry transparent with no request. With wrap=1 → second address is 0x0020.
- Back-pressure, FIFO_DEPTH=4, entry_ready=0, N_TILES=8 → exactly 4 acks, then mem_req stays 0. Raising entry_ready → all 8 entries arrive, in order.
- Random wait states on mem_ack (0–5 cycles) → mem_addr is stable while mem_req is high, and the entry sequence is identical to the zero-wait run.
- Reset asserted mid-FETCH with an ack pending → next cycle busy=0, mem_req=0, entry_valid=0. A fresh start then produces a full correct line.

Source files
------------

// File: rtl/screen_entry_fetcher_if.sv
// VRAM read port and ordered screen-entry stream used by the BG screen-entry fetcher.
// The fetcher is the master on both: it drives requests and produces entries.
interface sef_mem_if #(
   parameter int ADDR_W = 16
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ack;
   logic [15:0]       rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

interface sef_entry_if;
   logic        valid;
   logic [15:0] data;
   logic        transparent;
   logic        last;
   logic        ready;

   modport master (output valid, data, transparent, last, input ready);
   modport slave  (input valid, data, transparent, last, output ready);
endinterface

// File: rtl/screen_entry_fetcher.sv
// Fetches one scanline of BG screen-map entries (text or rotation layout) into an ordered FIFO.
// Latency: ack to entry_valid 1 cycle, 2 cycles/entry at zero wait; no request while the FIFO is full.
module sef_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_vld,
   input  logic [WIDTH-1:0]        wr_dat,
   input  logic                    rd_rdy,
   output logic                    rd_vld,
   output logic [WIDTH-1:0]        rd_dat,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             pop;

   assign rd_vld = (count != '0);
   assign pop    = rd_vld & rd_rdy;
   // Head reads as zero while empty so idle outputs are clean.
   assign rd_dat = rd_vld ? store[rd_ptr] : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         count <= count + {{PW{1'b0}}, wr_vld} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clock) begin
      if (wr_vld) store[wr_ptr] <= wr_dat;
   end
endmodule

module screen_entry_fetcher #(
   parameter int N_TILES    = 31,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 16,
   parameter int BASE_W     = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [9:0]        x0,
   input  logic [9:0]        y,
   input  logic [9:0]        hmax,
   input  logic [9:0]        vmax,
   input  logic              rotate,
   input  logic              wrap,
   input  logic [BASE_W-1:0] screen_base,
   output logic              busy,
   sef_mem_if.master         mem,
   sef_entry_if.master       entry
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [7:0]    LAST_IDX = 8'(N_TILES - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   typedef struct packed {
      logic        transparent;
      logic        last;
      logic [15:0] data;
   } entry_t;

   state_t            state, state_nxt;
   logic [7:0]        idx, idx_nxt;
   logic              req, req_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;

   logic [6:0]        x0_q;
   logic [9:0]        y_q, hmax_q, vmax_q;
   logic              rotate_q, wrap_q;
   logic [BASE_W-1:0] base_q;

   logic              push, pop, advance;
   entry_t            push_dat, head;
   logic              head_vld;
   logic [CW-1:0]     fifo_cnt;

   logic [7:0]        tx, col;
   logic [6:0]        row;
   logic [1:0]        blk;
   logic [31:0]       base_addr, text_addr, rot_addr;
   logic [ADDR_W-1:0] calc_addr;
   logic              ovf;
   logic [7:0]        sel_byte;

   // Map coordinates and byte address of entry idx from the captured line parameters.
   always_comb begin
      tx        = {1'b0, x0_q} + idx;
      col       = tx & {1'b0, hmax_q[9:3]};
      row       = y_q[9:3] & vmax_q[9:3];
      blk       = (hmax_q == 10'd511) ? {row[5], col[5]} : {1'b0, row[5]};
      base_addr = 32'(base_q) << 11;
      text_addr = base_addr + (32'(blk) << 11) + (32'(row[4:0]) << 6) + (32'(col[4:0]) << 1);
      rot_addr  = base_addr + 32'(row) * (32'(hmax_q[9:3]) + 32'd1) + 32'(col);
      calc_addr = ADDR_W'(rotate_q ? rot_addr : text_addr);
      ovf       = rotate_q && !wrap_q && (({tx, 3'b000} > {1'b0, hmax_q}) || (y_q > vmax_q));
      sel_byte  = addr[0] ? mem.rdata[15:8] : mem.rdata[7:0];
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      req_nxt   = req;
      addr_nxt  = addr;
      push      = 1'b0;
      push_dat  = '0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
               idx_nxt   = '0;
            end
         end
         FETCH: begin
            if (req) begin
               if (mem.ack) begin
                  req_nxt       = 1'b0;
                  push          = 1'b1;
                  push_dat.last = (idx == LAST_IDX);
                  push_dat.data = rotate_q ? {8'h00, sel_byte} : mem.rdata;
                  advance       = 1'b1;
               end
            end else if (fifo_cnt < FULL_CNT) begin
               // Out-of-map rotation tiles skip VRAM and take a single cycle.
               if (ovf) begin
                  push                 = 1'b1;
                  push_dat.transparent = 1'b1;
                  push_dat.last        = (idx == LAST_IDX);
                  advance              = 1'b1;
               end else begin
                  req_nxt  = 1'b1;
                  addr_nxt = calc_addr;
               end
            end
         end
         DRAIN: begin
            if (fifo_cnt == '0 || (fifo_cnt == CW'(1) && pop)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (advance) begin
         if (idx == LAST_IDX) state_nxt = DRAIN;
         else                 idx_nxt   = idx + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         req      <= 1'b0;
         addr     <= '0;
         x0_q     <= '0;
         y_q      <= '0;
         hmax_q   <= '0;
         vmax_q   <= '0;
         rotate_q <= 1'b0;
         wrap_q   <= 1'b0;
         base_q   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         req   <= req_nxt;
         addr  <= addr_nxt;
         if (state == IDLE && start) begin
            x0_q     <= x0[9:3];
            y_q      <= y;
            hmax_q   <= hmax;
            vmax_q   <= vmax;
            rotate_q <= rotate;
            wrap_q   <= wrap;
            base_q   <= screen_base;
         end
      end
   end

   sef_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .wr_vld (push),
      .wr_dat (push_dat),
      .rd_rdy (entry.ready),
      .rd_vld (head_vld),
      .rd_dat (head),
      .count  (fifo_cnt)
   );

   assign pop               = head_vld & entry.ready;
   assign busy              = (state != IDLE);
   assign mem.req           = req;
   assign mem.addr          = addr;
   assign entry.valid       = head_vld;
   assign entry.data        = head.data;
   assign entry.transparent = head.transparent;
   assign entry.last        = head.last;
endmodule

// File: tb/tb_screen_entry_fetcher.sv
// Randomized bench for screen_entry_fetcher against a line-level reference model.
module tb_screen_entry_fetcher;
   localparam int N     = 8;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic        tr;
      logic        last;
      logic [15:0] data;
   } ent_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [9:0] x0 = '0, y = '0, hmax = '0, vmax = '0;
   logic       rotate = 1'b0, wrap = 1'b0;
   logic [4:0] screen_base = '0;
   logic       busy;

   sef_mem_if #(.ADDR_W(16)) mem();
   sef_entry_if entry();

   screen_entry_fetcher #(.N_TILES(N), .FIFO_DEPTH(DEPTH), .ADDR_W(16), .BASE_W(5)) dut (
      .clock(clock), .reset(reset), .start(start), .x0(x0), .y(y), .hmax(hmax), .vmax(vmax),
      .rotate(rotate), .wrap(wrap), .screen_base(screen_base), .busy(busy),
      .mem(mem), .entry(entry)
   );

   always #5 clock = ~clock;

   int   total = 0, bad = 0;
   bit   chk_en = 0, line_go = 0, chk_idle = 0, req_seen = 0;
   logic [15:0] held_addr;
   int   ack_count = 0, max_wait = 0, ready_mode = 1;
   int   exp_req[$];
   ent_t exp_ent[$];
   int   obs_req[$];
   ent_t obs_ent[$];
   int   ln_x0, ln_y, ln_h, ln_v, ln_rot, ln_wrap, ln_base;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, want);
      end
   endtask

   task automatic fail_note(input string nm, input int val);
      total++;
      bad++;
      $display("FAIL %s: got %0h, want nothing", nm, val);
   endtask

   function automatic logic [15:0] mem_word(input int a);
      int h;
      h = (a & 32'hFFFE) * 40503 + 12345;
      return h[23:8];
   endfunction

   // Expected request addresses and entries for the whole line, straight from the map rules.
   task automatic build_line();
      for (int i = 0; i < N; i++) begin
         int tx, c, r, a, blk;
         bit ovf;
         ent_t e;
         logic [15:0] w;
         tx  = ((ln_x0 / 8) + i) % 256;
         c   = tx & (ln_h / 8);
         r   = (ln_y / 8) & (ln_v / 8);
         ovf = (ln_rot != 0) && (ln_wrap == 0) && (tx * 8 > ln_h || ln_y > ln_v);
         if (ln_rot != 0) a = ln_base * 2048 + r * ((ln_h + 1) / 8) + c;
         else begin
            blk = (ln_h == 511) ? ((r / 32) % 2) * 2 + (c / 32) % 2 : (r / 32) % 2;
            a   = ln_base * 2048 + blk * 2048 + (r % 32) * 64 + (c % 32) * 2;
         end
         a      = a % 65536;
         e      = '0;
         e.last = (i == N - 1);
         if (ovf) e.tr = 1'b1;
         else begin
            exp_req.push_back(a);
            w = mem_word(a);
            if (ln_rot == 0)   e.data = w;
            else if (a % 2)    e.data = {8'h00, w[15:8]};
            else               e.data = {8'h00, w[7:0]};
         end
         exp_ent.push_back(e);
      end
   endtask

   // VRAM responder and consumer, driven just after the active edge.
   int wait_left = 0;
   bit in_req = 0;
   always @(posedge clock) begin
      #1;
      mem.rdata = 16'($urandom);
      if (mem.req && !reset) begin
         if (!in_req) begin
            in_req    = 1;
            wait_left = $urandom_range(max_wait, 0);
         end
         if (wait_left == 0) begin
            mem.ack   = 1'b1;
            mem.rdata = mem_word(int'(mem.addr));
            in_req    = 0;
         end else begin
            mem.ack = 1'b0;
            wait_left--;
         end
      end else begin
         mem.ack = 1'b0;
         in_req  = 0;
      end
      case (ready_mode)
         0:       entry.ready = 1'b0;
         1:       entry.ready = 1'b1;
         default: entry.ready = 1'($urandom_range(1, 0));
      endcase
   end

   // Compare process: request order/stability, entry stream, busy.
   always @(negedge clock) begin
      if (chk_en) begin
         if (chk_idle) begin
            check("busy_after_last", {31'b0, busy}, 0);
            chk_idle = 0;
         end else if (line_go && exp_ent.size() != 0) begin
            check("busy_during_line", {31'b0, busy}, 1);
         end
         if (mem.req) begin
            if (!req_seen) begin
               req_seen  = 1;
               held_addr = mem.addr;
               obs_req.push_back(int'(mem.addr));
               if (exp_req.size() == 0) fail_note("unexpected_req", int'(mem.addr));
               else check("req_addr", {16'b0, mem.addr}, 32'(exp_req.pop_front()));
            end else begin
               check("addr_stable", {16'b0, mem.addr}, {16'b0, held_addr});
            end
            if (mem.ack) begin
               req_seen = 0;
               ack_count++;
            end
         end else begin
            req_seen = 0;
         end
         if (entry.valid && entry.ready) begin
            ent_t g, e;
            g.tr   = entry.transparent;
            g.last = entry.last;
            g.data = entry.data;
            obs_ent.push_back(g);
            if (exp_ent.size() == 0) fail_note("unexpected_entry", int'(g));
            else begin
               e = exp_ent.pop_front();
               check("entry", {14'b0, g}, {14'b0, e});
               if (e.last) chk_idle = 1;
            end
         end
      end
   end

   task automatic start_line(input int bx0, input int by, input int bh, input int bv,
                             input int brot, input int bwrap, input int bbase,
                             input int mw, input int rm);
      @(posedge clock); #1;
      x0 = 10'(bx0); y = 10'(by); hmax = 10'(bh); vmax = 10'(bv);
      rotate = 1'(brot); wrap = 1'(bwrap); screen_base = 5'(bbase);
      start = 1'b1; max_wait = mw; ready_mode = rm;
      ln_x0 = bx0; ln_y = by; ln_h = bh; ln_v = bv; ln_rot = brot; ln_wrap = bwrap; ln_base = bbase;
      @(posedge clock); #1;
      start = 1'b0;
      x0 = 10'($urandom); y = 10'($urandom); hmax = 10'($urandom); vmax = 10'($urandom);
      rotate = 1'($urandom); wrap = 1'($urandom); screen_base = 5'($urandom);
      obs_req.delete(); obs_ent.delete(); ack_count = 0;
      build_line();
      line_go = 1;
   endtask

   task automatic finish_line();
      int k = 0;
      while (exp_ent.size() != 0 && k < 4000) begin
         @(posedge clock);
         k++;
      end
      if (exp_ent.size() != 0) begin
         fail_note("line_timeout", exp_ent.size());
         exp_ent.delete();
         exp_req.delete();
      end
      repeat (3) @(posedge clock);
      #1;
      line_go = 0;
      check("req_leftover", 32'(exp_req.size()), 0);
   endtask

   task automatic check_req(input string nm, input int i, input int want);
      if (i < obs_req.size()) check(nm, 32'(obs_req[i]), 32'(want));
      else fail_note({nm, "_missing"}, i);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ent_t ref_ent[$];
      int rx, ry, rh, rv, rr, rw, rb, k;
      bit hit;
      mem.ack = 1'b0; mem.rdata = '0; entry.ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy",  {31'b0, busy}, 0);
      check("rst_req",   {31'b0, mem.req}, 0);
      check("rst_addr",  {16'b0, mem.addr}, 0);
      check("rst_valid", {31'b0, entry.valid}, 0);
      check("rst_data",  {16'b0, entry.data}, 0);
      check("rst_tr",    {31'b0, entry.transparent}, 0);
      check("rst_last",  {31'b0, entry.last}, 0);
      chk_en = 1;

      start_line(0, 8, 255, 255, 0, 0, 2, 0, 1); finish_line();
      check_req("text_a0", 0, 'h1040); check_req("text_a1", 1, 'h1042);
      check_req("text_a2", 2, 'h1044); check_req("text_a3", 3, 'h1046);

      start_line(248, 0, 511, 511, 0, 0, 0, 0, 1); finish_line();
      check_req("quad_a0", 0, 'h003E); check_req("quad_a1", 1, 'h0800);
      start_line(248, 256, 511, 511, 0, 0, 0, 0, 1); finish_line();
      check_req("quad_b0", 0, 'h103E); check_req("quad_b1", 1, 'h1800);

      start_line(120, 16, 127, 127, 1, 0, 0, 0, 1); finish_line();
      check("rot_nreq", 32'(obs_req.size()), 1);
      check_req("rot_a0", 0, 'h002F);
      if (obs_ent.size() >= 2) begin
         check("rot_hibyte", {16'b0, obs_ent[0].data}, 'h001C);
         check("rot_transp", {31'b0, obs_ent[1].tr}, 1);
      end else fail_note("rot_entries", obs_ent.size());
      start_line(120, 16, 127, 127, 1, 1, 0, 0, 1); finish_line();
      check_req("rot_wrap_a1", 1, 'h0020);

      start_line(0, 8, 255, 255, 0, 0, 2, 0, 0);
      repeat (20) @(posedge clock);
      #1 start = 1'b1; x0 = 10'd512;
      @(posedge clock); #1 start = 1'b0;
      repeat (60) @(posedge clock);
      @(negedge clock);
      check("bp_acks", 32'(ack_count), DEPTH);
      check("bp_req_low", {31'b0, mem.req}, 0);
      ready_mode = 1;
      finish_line();
      check("bp_count", 32'(obs_ent.size()), N);

      for (int t = 0; t < 6; t++) begin
         rx = $urandom_range(1023, 0); ry = $urandom_range(1023, 0);
         rh = (128 << $urandom_range(3, 0)) - 1; rv = (128 << $urandom_range(3, 0)) - 1;
         rr = $urandom_range(1, 0); rw = $urandom_range(1, 0); rb = $urandom_range(31, 0);
         start_line(rx, ry, rh, rv, rr, rw, rb, 0, 1); finish_line();
         ref_ent = obs_ent;
         start_line(rx, ry, rh, rv, rr, rw, rb, 5, 2);
         repeat ($urandom_range(8, 2)) @(negedge clock);
         if (exp_ent.size() >= 3) begin
            @(posedge clock); #1 start = 1'b1; x0 = 10'($urandom);
            @(posedge clock); #1 start = 1'b0;
         end
         finish_line();
         check("waits_len", 32'(obs_ent.size()), 32'(ref_ent.size()));
         for (int j = 0; j < ref_ent.size() && j < obs_ent.size(); j++)
            check("waits_seq", {14'b0, obs_ent[j]}, {14'b0, ref_ent[j]});
      end

      start_line(16, 40, 255, 255, 0, 0, 3, 0, 1);
      hit = 0;
      k   = 0;
      while (!hit && k < 100) begin
         @(negedge clock);
         k++;
         if (mem.ack && k > 4) hit = 1;
      end
      if (!hit) fail_note("reset_ack_wait", k);
      chk_en = 0;
      reset  = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      exp_ent.delete(); exp_req.delete();
      line_go = 0; chk_idle = 0; req_seen = 0;
      @(negedge clock);
      check("mid_rst_busy",  {31'b0, busy}, 0);
      check("mid_rst_req",   {31'b0, mem.req}, 0);
      check("mid_rst_valid", {31'b0, entry.valid}, 0);
      chk_en = 1;
      start_line(16, 40, 255, 255, 0, 0, 3, 2, 2); finish_line();
      check("post_rst_count", 32'(obs_ent.size()), N);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
